// File: rtl/pattern_gen_32b.sv
// Incrementing-word test-pattern source for the 32-bit user TX link.
// Words go out in bursts separated by idle gaps, with optional single-word error injection.
module pattern_gen_32b #(
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter logic [31:0] STEP       = 32'h0000_0004,
    parameter int          BURST_LEN  = 256,
    parameter int          GAP_CYCLES = 16
) (
    input  logic        clk_usr,
    input  logic        rst,
    input  logic        enable,
    input  logic        inject_err,
    output logic [31:0] usr_tx,
    output logic        usr_tx_valid,
    input  logic        usr_tx_ready,
    output logic        busy,
    output logic [31:0] word_cnt,
    output logic [31:0] burst_cnt
);
    // state | meaning
    // IDLE  | no words presented, waiting for enable
    // SEND  | burst in progress, usr_tx_valid high
    // GAP   | idle gap between bursts, enable sampled on its last cycle
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam int          GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0] BEAT_LAST  = 16'(BURST_LEN - 1);

    state_t        state;
    logic [31:0]   next_data;
    logic [15:0]   beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic          pend;

    logic          xfer;
    logic          pend_nxt;
    logic [31:0]   data_step;
    logic [31:0]   corrupt;

    always_comb begin
        xfer      = usr_tx_valid && usr_tx_ready;
        // a pulse arriving while a corruption is still pending is absorbed
        pend_nxt  = (pend && !xfer) || (inject_err && !pend);
        data_step = next_data + STEP;
        corrupt   = {31'b0, pend_nxt};
    end

    always_ff @(posedge clk_usr or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            next_data    <= SEED;
            beat_cnt     <= 16'd0;
            gap_cnt      <= '0;
            pend         <= 1'b0;
            usr_tx       <= SEED;
            usr_tx_valid <= 1'b0;
            busy         <= 1'b0;
            word_cnt     <= 32'd0;
            burst_cnt    <= 32'd0;
        end else begin
            pend <= pend_nxt;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state        <= SEND;
                        usr_tx_valid <= 1'b1;
                        busy         <= 1'b1;
                        usr_tx       <= next_data ^ corrupt;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        next_data <= data_step;
                        word_cnt  <= word_cnt + 32'd1;
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt  <= 16'd0;
                            burst_cnt <= burst_cnt + 32'd1;
                            if (GAP_CYCLES > 0) begin
                                state        <= GAP;
                                gap_cnt      <= GAP_LOAD;
                                usr_tx_valid <= 1'b0;
                            end else if (enable) begin
                                usr_tx <= data_step ^ corrupt;
                            end else begin
                                state        <= IDLE;
                                usr_tx_valid <= 1'b0;
                                busy         <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                            usr_tx   <= data_step ^ corrupt;
                        end
                    end else if (inject_err && !pend) begin
                        // stalled word is corrupted in place; the sequence itself is untouched
                        usr_tx <= usr_tx ^ 32'h0000_0001;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (enable) begin
                            state        <= SEND;
                            usr_tx_valid <= 1'b1;
                            usr_tx       <= next_data ^ corrupt;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state        <= IDLE;
                    usr_tx_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule
